// File: rtl/masking_pkg.sv
// Shared definitions for the masked-AND issue path: scheduler states and
// Galois LFSR feedback masks for the supported state widths.
package masking_pkg;

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        RUN      = 2'd1,
        RESEED   = 2'd2
    } sched_state_t;

    // Right-shifting Galois masks of maximal-length polynomials.
    localparam logic [63:0] TAPS_4  = 64'h0000_0000_0000_000C;
    localparam logic [63:0] TAPS_8  = 64'h0000_0000_0000_00B8;
    localparam logic [63:0] TAPS_16 = 64'h0000_0000_0000_B400;
    localparam logic [63:0] TAPS_24 = 64'h0000_0000_00E1_0000;
    localparam logic [63:0] TAPS_32 = 64'h0000_0000_8020_0003;
    localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            4:       return TAPS_4;
            8:       return TAPS_8;
            16:      return TAPS_16;
            24:      return TAPS_24;
            64:      return TAPS_64;
            default: return TAPS_32;
        endcase
    endfunction

endpackage

// File: rtl/mask_lfsr.sv
// Galois LFSR supplying fresh mask bits; a zero seed is never loaded so the
// register cannot lock up in the all-zero state.
module mask_lfsr
    import masking_pkg::*;
#(
    parameter int LFSR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] state_out
);

    localparam logic [63:0]       TAPS_FULL = lfsr_taps(LFSR_W);
    localparam logic [LFSR_W-1:0] TAPS      = TAPS_FULL[LFSR_W-1:0];

    logic [LFSR_W-1:0] lfsr_q;

    // A load takes priority over a step issued in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= '0;
        end else if (load && (seed != '0)) begin
            lfsr_q <= seed;
        end else if (step) begin
            lfsr_q <= {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    assign state_out = lfsr_q;

endmodule

// File: rtl/dom_and_sched.sv
// Issue scheduler for external DOM AND gadgets: one masked issue per cycle,
// fresh Z per issue, fixed-latency capture into a credit-protected result FIFO.
module dom_and_sched
    import masking_pkg::*;
#(
    parameter int W          = 1,
    parameter int LAT        = 1,
    parameter int DEPTH      = 4,
    parameter int RESEED_OPS = 256,
    parameter int LFSR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed_data,
    output logic              reseed_req,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_ax,
    input  logic [W-1:0]      in_ay,
    input  logic [W-1:0]      in_bx,
    input  logic [W-1:0]      in_by,
    output logic [W-1:0]      g_ax,
    output logic [W-1:0]      g_ay,
    output logic [W-1:0]      g_bx,
    output logic [W-1:0]      g_by,
    output logic [W-1:0]      g_z,
    input  logic [W-1:0]      g_aq,
    input  logic [W-1:0]      g_bq,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_aq,
    output logic [W-1:0]      out_bq
);

    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    sched_state_t      state, next_state;
    logic              seed_ok, issue, capture, fifo_rd, last_op, credit_ok;
    logic [31:0]       op_count;
    logic [LAT:0]      issue_pipe;
    logic [CW-1:0]     inflight, fifo_count;
    logic [CW:0]       occupancy;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [W-1:0]      mem_aq [DEPTH];
    logic [W-1:0]      mem_bq [DEPTH];
    logic [LFSR_W-1:0] lfsr_state;
    logic              lfsr_unused;

    assign seed_ok   = seed_valid && (seed_data != '0);
    assign issue     = in_valid && in_ready;
    assign last_op   = (RESEED_OPS != 0) && (op_count == 32'(RESEED_OPS - 1));
    assign occupancy = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit_ok = occupancy < DEPTH_C;
    assign capture   = issue_pipe[LAT];
    assign out_valid = fifo_count != '0;
    assign fifo_rd   = out_valid && out_ready;
    assign out_aq    = mem_aq[rd_ptr];
    assign out_bq    = mem_bq[rd_ptr];
    assign lfsr_unused = ^lfsr_state;

    mask_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .load      (seed_ok),
        .seed      (seed_data),
        .step      (issue),
        .state_out (lfsr_state)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= UNSEEDED;
        else     state <= next_state;
    end

    // A seed arriving together with the last permitted issue keeps us in RUN.
    always_comb begin
        next_state = state;
        case (state)
            UNSEEDED: if (seed_ok) next_state = RUN;
            RUN:      if (!seed_ok && issue && last_op) next_state = RESEED;
            RESEED:   if (seed_ok) next_state = RUN;
            default:  next_state = UNSEEDED;
        endcase
    end

    always_comb begin
        reseed_req = (state != RUN);
        in_ready   = (state == RUN) && credit_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (seed_ok) begin
            op_count <= '0;
        end else if (issue) begin
            op_count <= last_op ? '0 : op_count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_ax <= '0;
            g_ay <= '0;
            g_bx <= '0;
            g_by <= '0;
            g_z  <= '0;
        end else if (issue) begin
            g_ax <= in_ax;
            g_ay <= in_ay;
            g_bx <= in_bx;
            g_by <= in_by;
            g_z  <= lfsr_state[W-1:0];
        end
    end

    // Stage 0 marks the g_* register; the remaining LAT stages track the gadget.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_pipe <= '0;
            inflight   <= '0;
        end else begin
            issue_pipe <= {issue_pipe[LAT-1:0], issue};
            case ({issue, capture})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (capture) wr_ptr <= wr_ptr + AW'(1);
            if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({capture, fifo_rd})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            mem_aq[wr_ptr] <= g_aq;
            mem_bq[wr_ptr] <= g_bq;
        end
    end

endmodule

// File: tb/tb_dom_and_sched.sv
// Bench for dom_and_sched: a queue-based model of issue, gadget latency and
// result buffering is compared with the DUT after every clock edge.
module tb_dom_and_sched;

    localparam int W          = 8;
    localparam int LAT        = 1;
    localparam int DEPTH      = 4;
    localparam int RESEED_OPS = 4;
    localparam int LFSR_W     = 32;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic              clk = 1'b0;
    logic              rst;
    logic              seed_valid;
    logic [LFSR_W-1:0] seed_data;
    logic              reseed_req;
    logic              in_valid, in_ready;
    logic [W-1:0]      in_ax, in_ay, in_bx, in_by;
    logic [W-1:0]      g_ax, g_ay, g_bx, g_by, g_z;
    logic [W-1:0]      g_aq, g_bq;
    logic              out_valid, out_ready;
    logic [W-1:0]      out_aq, out_bq;

    always #5 clk = ~clk;

    dom_and_sched #(
        .W(W), .LAT(LAT), .DEPTH(DEPTH), .RESEED_OPS(RESEED_OPS), .LFSR_W(LFSR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .seed_valid(seed_valid), .seed_data(seed_data), .reseed_req(reseed_req),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ax(in_ax), .in_ay(in_ay), .in_bx(in_bx), .in_by(in_by),
        .g_ax(g_ax), .g_ay(g_ay), .g_bx(g_bx), .g_by(g_by), .g_z(g_z),
        .g_aq(g_aq), .g_bq(g_bq),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_aq(out_aq), .out_bq(out_bq)
    );

    // Behavioural DOM AND gadget with LAT output registers.
    logic [W-1:0] gad_aq [LAT];
    logic [W-1:0] gad_bq [LAT];
    always @(posedge clk) begin
        gad_aq[0] <= (g_ax & g_ay) ^ (g_ax & g_by) ^ g_z;
        gad_bq[0] <= (g_bx & g_by) ^ (g_bx & g_ay) ^ g_z;
        for (int i = 1; i < LAT; i++) begin
            gad_aq[i] <= gad_aq[i-1];
            gad_bq[i] <= gad_bq[i-1];
        end
    end
    assign g_aq = gad_aq[LAT-1];
    assign g_bq = gad_bq[LAT-1];

    typedef struct {
        logic [W-1:0] aq;
        logic [W-1:0] bq;
        logic [W-1:0] prod;
        int           due;
    } res_t;

    res_t         pend[$];
    res_t         fifo_q[$];
    int           m_state;
    int           m_ops;
    int           edge_n;
    logic [31:0]  m_lfsr;
    logic [W-1:0] m_gax, m_gay, m_gbx, m_gby, m_gz;
    int           errors = 0;
    int           checks = 0;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [W-1:0] ax, input logic [W-1:0] ay,
                                 input logic [W-1:0] bx, input logic [W-1:0] by, input logic ordy);
        in_valid  = iv;
        in_ax     = ax;
        in_ay     = ay;
        in_bx     = bx;
        in_by     = by;
        out_ready = ordy;
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic modelEdge();
        bit   ready, iss, sok;
        res_t r;
        edge_n++;
        if (rst) begin
            pend.delete();
            fifo_q.delete();
            m_state = 0;
            m_ops   = 0;
            {m_gax, m_gay, m_gbx, m_gby, m_gz} = '0;
            return;
        end
        ready = (m_state == 1) && (pend.size() + fifo_q.size() < DEPTH);
        iss   = in_valid && ready;
        sok   = seed_valid && (seed_data != 0);
        if (fifo_q.size() > 0 && out_ready) void'(fifo_q.pop_front());
        if (pend.size() > 0 && pend[0].due == edge_n) fifo_q.push_back(pend.pop_front());
        if (iss) begin
            m_gax  = in_ax;
            m_gay  = in_ay;
            m_gbx  = in_bx;
            m_gby  = in_by;
            m_gz   = m_lfsr[W-1:0];
            r.aq   = (in_ax & in_ay) ^ (in_ax & in_by) ^ m_gz;
            r.bq   = (in_bx & in_by) ^ (in_bx & in_ay) ^ m_gz;
            r.prod = (in_ax ^ in_bx) & (in_ay ^ in_by);
            r.due  = edge_n + 1 + LAT;
            pend.push_back(r);
            m_lfsr = lfsr_next(m_lfsr);
            m_ops++;
            if (m_ops == RESEED_OPS) begin
                m_ops   = 0;
                m_state = 2;
            end
        end
        if (sok) begin
            m_lfsr  = seed_data;
            m_ops   = 0;
            m_state = 1;
        end
    endtask

    task automatic compareModel();
        checkOutput("in_ready", in_ready, (m_state == 1) && (pend.size() + fifo_q.size() < DEPTH));
        checkOutput("reseed_req", reseed_req, m_state != 1);
        checkOutput("out_valid", out_valid, fifo_q.size() > 0);
        if (fifo_q.size() > 0) begin
            checkOutput("out_aq", out_aq, fifo_q[0].aq);
            checkOutput("out_bq", out_bq, fifo_q[0].bq);
            checkOutput("out_product", out_aq ^ out_bq, fifo_q[0].prod);
        end
        checkOutput("g_shares", {g_ax, g_ay, g_bx, g_by}, {m_gax, m_gay, m_gbx, m_gby});
        checkOutput("g_z", g_z, m_gz);
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        compareModel();
    endtask

    int accepted, pops, issued, cyc;

    initial begin
        edge_n = 0;
        m_lfsr = '0;
        rst = 1'b1;
        seed_valid = 1'b0;
        seed_data = '0;
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("reset_reseed_req", reseed_req, 1);
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_g_z", g_z, 0);

        // No seed: requests must be refused and g_* must not move.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 1'b1);
            tick();
        end
        checkOutput("unseeded_g_ax", g_ax, 0);
        checkOutput("unseeded_in_ready", in_ready, 0);
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b1);

        seed_valid = 1'b1;
        seed_data  = 32'h0;
        tick();
        checkOutput("zero_seed_ignored", reseed_req, 1);
        seed_data = 32'h1;
        tick();
        seed_valid = 1'b0;
        checkOutput("seed1_reseed_req", reseed_req, 0);
        checkOutput("seed1_in_ready", in_ready, 1);

        // x=1, y=1 split as ax=1,bx=0 / ay=0,by=1.
        applyStimulus(1'b1, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b1);
        checkOutput("first_g_z", g_z, 8'h01);
        checkOutput("first_g_ax", g_ax, 8'h01);
        tick();
        checkOutput("lat_t1_out_valid", out_valid, 0);
        tick();
        checkOutput("lat_t2_out_valid", out_valid, 1);
        checkOutput("lat_t2_product", out_aq ^ out_bq, 8'h01);
        checkOutput("lat_t2_out_bq", out_bq, 8'h01);
        tick();

        // Eight back-to-back requests against a stalled consumer; a mid-burst
        // seed clears the op counter so only FIFO credit limits acceptance.
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'(i * 17 + 3), 8'(i * 29 + 1), 8'(i * 7), 8'(i * 51 + 9), 1'b0);
            seed_valid = (i == 2);
            seed_data  = 32'h1234_5678;
            if (in_ready) accepted++;
            tick();
        end
        seed_valid = 1'b0;
        checkOutput("burst_accepted", accepted, 4);
        checkOutput("burst_in_ready", in_ready, 0);

        applyStimulus(1'b0, '0, '0, '0, '0, 1'b1);
        pops = 0;
        for (int i = 0; i < 20 && pops < 4; i++) begin
            if (out_valid) pops++;
            tick();
        end
        checkOutput("drain_pops", pops, 4);
        checkOutput("resume_in_ready", in_ready, 1);
        applyStimulus(1'b1, 8'h0F, 8'hF0, 8'h33, 8'hCC, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b1);
        tick();

        // Forced reseed after RESEED_OPS issues.
        seed_valid = 1'b1;
        seed_data  = 32'h5;
        tick();
        seed_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(i + 1), 8'(i + 2), 8'(i + 3), 8'(i + 4), 1'b1);
            checkOutput("reseed_burst_ready", in_ready, 1);
            tick();
        end
        checkOutput("reseed_req_set", reseed_req, 1);
        checkOutput("reseed_in_ready", in_ready, 0);
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b1);
        seed_valid = 1'b1;
        seed_data  = 32'hACE1;
        tick();
        seed_valid = 1'b0;
        checkOutput("ace1_reseed_req", reseed_req, 0);
        applyStimulus(1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
        tick();
        checkOutput("ace1_g_z", g_z, 8'hE1);

        // Random traffic with random backpressure and reseeds.
        issued = 0;
        cyc = 0;
        while (issued < 1000 && cyc < 20000) begin
            applyStimulus($urandom_range(3) != 0, 8'($urandom), 8'($urandom), 8'($urandom),
                          8'($urandom), $urandom_range(4) != 0);
            seed_valid = reseed_req && ($urandom_range(1) == 1);
            seed_data  = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
            if (in_valid && in_ready) issued++;
            tick();
            cyc++;
        end
        seed_valid = 1'b0;
        checkOutput("random_issue_budget", issued >= 1000, 1);

        // Drain, then build up FIFO contents and an in-flight issue before reset.
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b1);
        seed_valid = 1'b1;
        seed_data  = 32'h77;
        tick();
        seed_valid = 1'b0;
        for (int i = 0; i < 12 && (pend.size() + fifo_q.size()) > 0; i++) tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(i + 5), 8'(i + 6), 8'(i + 7), 8'(i + 8), 1'b0);
            tick();
        end
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
        tick();
        tick();
        checkOutput("prereset_fifo_valid", out_valid, 1);
        applyStimulus(1'b1, 8'h99, 8'h66, 8'h55, 8'hAA, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
        rst = 1'b1;
        tick();
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_in_ready", in_ready, 0);
        checkOutput("midreset_reseed_req", reseed_req, 1);
        rst = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b1);
        tick();
        tick();
        checkOutput("postreset_out_valid", out_valid, 0);
        checkOutput("postreset_g_z", g_z, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
